// File: rtl/iob_double2ptfloat_pkg.sv
// Shared IEEE-754 double constants and input classification for the double -> pt-float converter.
package iob_double2ptfloat_pkg;

    localparam int unsigned FP_DP_W     = 64;
    localparam int unsigned FP_DP_EXP_W = 11;
    localparam int unsigned FP_DP_MAN_W = 52;
    localparam int          FP_DP_BIAS  = 1023;
    localparam logic [FP_DP_EXP_W-1:0] FP_DP_EXP_INF = '1;

    typedef enum logic [1:0] {
        KindNum,
        KindZero,
        KindInf,
        KindNan
    } fp_kind_t;

    function automatic fp_kind_t classify(input logic [FP_DP_W-1:0] fp);
        logic [FP_DP_EXP_W-1:0] e;
        logic [FP_DP_MAN_W-1:0] f;
        e = fp[FP_DP_W-2 -: FP_DP_EXP_W];
        f = fp[FP_DP_MAN_W-1:0];
        if (e == FP_DP_EXP_INF) begin
            return (f != '0) ? KindNan : KindInf;
        end
        if (e == '0 && f == '0) begin
            return KindZero;
        end
        return KindNum;
    endfunction

endpackage

// File: rtl/iob_double2ptfloat_rne_round.sv
// Round-to-nearest-even truncation of an IN_W-bit magnitude to its top OUT_W bits.
module iob_rne_round #(
    parameter int unsigned IN_W  = 53,
    parameter int unsigned OUT_W = 27
) (
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] mag,
    output logic             carry,
    output logic             inexact
);

    logic [OUT_W-1:0] kept;
    logic             guard;
    logic             sticky;
    logic             round_up;

    assign kept     = data[IN_W-1 -: OUT_W];
    assign guard    = data[IN_W-OUT_W-1];
    assign sticky   = |data[IN_W-OUT_W-2:0];
    assign round_up = guard & (kept[0] | sticky);
    assign inexact  = guard | sticky;

    assign {carry, mag} = {1'b0, kept} + (OUT_W + 1)'(round_up);

endmodule

// File: rtl/iob_double2ptfloat.sv
// IEEE double -> unpacked pt-float (signed exponent, two's-complement mantissa), multi-cycle
// with iterative subnormal normalization and RNE rounding under a start/done handshake.
module iob_double2ptfloat
    import iob_double2ptfloat_pkg::*;
#(
    parameter int  DATA_W    = 32,
    parameter int  EW_W      = 4,
    localparam int MAN_MAX_W = DATA_W - EW_W,
    localparam int EXP_MAX_W = (1 << EW_W) - 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cke_i,
    input  logic                 start_i,
    input  logic [63:0]          fp_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [EXP_MAX_W-1:0] exp_o,
    output logic [MAN_MAX_W-1:0] man_o,
    output logic                 inexact_o,
    output logic                 nan_o
);

    localparam logic [EXP_MAX_W-1:0] EXP_MIN     = {1'b1, {(EXP_MAX_W-1){1'b0}}};
    localparam logic [EXP_MAX_W-1:0] EXP_POS_MAX = {1'b0, {(EXP_MAX_W-1){1'b1}}};
    localparam logic [MAN_MAX_W-1:0] MAN_POS_MAX = {1'b0, {(MAN_MAX_W-1){1'b1}}};
    localparam logic [MAN_MAX_W-1:0] MAN_ONE     = {2'b01, {(MAN_MAX_W-2){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StNorm,
        StRound,
        StDone
    } state_t;

    state_t                   state, state_nxt;
    logic [FP_DP_W-1:0]       fp_r;
    logic                     sign;
    logic [FP_DP_MAN_W:0]     sig;
    logic [EXP_MAX_W-1:0]     wexp;
    fp_kind_t                 kind;

    logic [FP_DP_EXP_W-1:0]   in_e;
    logic [FP_DP_MAN_W-1:0]   in_f;
    fp_kind_t                 in_kind;
    logic                     in_subnormal;

    logic [MAN_MAX_W-2:0]     rnd_mag;
    logic                     rnd_carry;
    logic                     rnd_inexact;
    logic [MAN_MAX_W-1:0]     mag_full;
    logic [MAN_MAX_W-1:0]     res_man;
    logic [EXP_MAX_W-1:0]     res_exp;

    assign in_e         = fp_r[FP_DP_W-2 -: FP_DP_EXP_W];
    assign in_f         = fp_r[FP_DP_MAN_W-1:0];
    assign in_kind      = classify(fp_r);
    assign in_subnormal = (in_kind == KindNum) && (in_e == '0);

    iob_rne_round #(
        .IN_W  (FP_DP_MAN_W + 1),
        .OUT_W (MAN_MAX_W - 1)
    ) u_round (
        .data    (sig),
        .mag     (rnd_mag),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    // A rounding carry means the magnitude became exactly 2^(MAN_MAX_W-1): renormalize by one.
    assign mag_full = rnd_carry ? MAN_ONE : {1'b0, rnd_mag};
    assign res_exp  = wexp + EXP_MAX_W'(rnd_carry);
    assign res_man  = sign ? -mag_full : mag_full;

    assign busy_o = (state != StIdle);
    assign done_o = (state == StDone);

    always_comb begin
        state_nxt = state;
        unique case (state)
            StIdle:   if (start_i) state_nxt = StUnpack;
            StUnpack: state_nxt = in_subnormal ? StNorm : StRound;
            // Leave after the shift that brings the leading one into bit 52.
            StNorm:   if (sig[FP_DP_MAN_W-1]) state_nxt = StRound;
            StRound:  state_nxt = StDone;
            StDone:   state_nxt = StIdle;
            default:  state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= StIdle;
            fp_r      <= '0;
            sign      <= 1'b0;
            sig       <= '0;
            wexp      <= '0;
            kind      <= KindZero;
            exp_o     <= '0;
            man_o     <= '0;
            inexact_o <= 1'b0;
            nan_o     <= 1'b0;
        end else if (cke_i) begin
            state <= state_nxt;
            unique case (state)
                StIdle: begin
                    if (start_i) fp_r <= fp_i;
                end
                StUnpack: begin
                    sign <= fp_r[FP_DP_W-1];
                    kind <= in_kind;
                    if (in_e == '0) begin
                        sig  <= {1'b0, in_f};
                        wexp <= EXP_MAX_W'(2 - (FP_DP_BIAS - 1));
                    end else begin
                        sig  <= {1'b1, in_f};
                        wexp <= EXP_MAX_W'(in_e) - EXP_MAX_W'(FP_DP_BIAS - 2);
                    end
                end
                StNorm: begin
                    sig  <= sig << 1;
                    wexp <= wexp - EXP_MAX_W'(1);
                end
                StRound: begin
                    unique case (kind)
                        KindZero: begin
                            exp_o     <= EXP_MIN;
                            man_o     <= '0;
                            inexact_o <= 1'b0;
                            nan_o     <= 1'b0;
                        end
                        KindInf: begin
                            exp_o     <= EXP_POS_MAX;
                            man_o     <= sign ? -MAN_POS_MAX : MAN_POS_MAX;
                            inexact_o <= 1'b1;
                            nan_o     <= 1'b0;
                        end
                        KindNan: begin
                            exp_o     <= EXP_POS_MAX;
                            man_o     <= MAN_POS_MAX;
                            inexact_o <= 1'b1;
                            nan_o     <= 1'b1;
                        end
                        default: begin
                            exp_o     <= res_exp;
                            man_o     <= res_man;
                            inexact_o <= rnd_inexact;
                            nan_o     <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_double2ptfloat.sv
// Self-checking bench for iob_double2ptfloat: directed vectors, control cases and random doubles
// compared against an arithmetic reference model.
module tb_iob_double2ptfloat;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cke_i;
    logic        start_i;
    logic [63:0] fp_i;
    logic        busy_o;
    logic        done_o;
    logic [14:0] exp_o;
    logic [27:0] man_o;
    logic        inexact_o;
    logic        nan_o;

    int total = 0;
    int bad   = 0;

    logic [14:0] d_exp;
    logic [27:0] d_man;
    logic        d_inx;
    logic        d_nan;
    int          d_lat;

    always #5 clk = ~clk;

    iob_double2ptfloat #(
        .DATA_W (32),
        .EW_W   (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .cke_i     (cke_i),
        .start_i   (start_i),
        .fp_i      (fp_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .exp_o     (exp_o),
        .man_o     (man_o),
        .inexact_o (inexact_o),
        .nan_o     (nan_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Value = M * 2^(exp-28) with M's leading one at bit 26, rounded to nearest-even.
    task automatic model(input logic [63:0] v, output logic [14:0] mexp, output logic [27:0] mman,
                         output logic minx, output logic mnan, output int mlat);
        logic        s;
        int          e, n, sh, p;
        logic [51:0] f;
        logic [63:0] m, q, r, half;
        logic        up;
        s = v[63];
        e = int'(v[62:52]);
        f = v[51:0];
        minx = 1'b0;
        mnan = 1'b0;
        mlat = 3;
        if (e == 2047) begin
            mexp = 15'(16383);
            mman = (s && f == 0) ? 28'(-(2 ** 27 - 1)) : 28'(2 ** 27 - 1);
            minx = 1'b1;
            mnan = (f != 0);
        end else if (e == 0 && f == 0) begin
            mexp = 15'(-16384);
            mman = '0;
        end else begin
            m = (e != 0) ? {11'd0, 1'b1, f} : {12'd0, f};
            p = (e != 0) ? e - 1075 : -1074;
            n = 0;
            for (int i = 0; i < 53; i++) if (m[i]) n = i;
            if (n >= 26) begin
                sh = n - 26;
                q = m >> sh;
                r = m - (q << sh);
                up = 1'b0;
                if (sh > 0) begin
                    half = 64'd1 << (sh - 1);
                    up = (r > half) || (r == half && q[0]);
                end
                q = q + 64'(up);
                minx = (r != 0);
                if (q == (64'd1 << 27)) begin
                    q = q >> 1;
                    n++;
                end
            end else begin
                q = m << (26 - n);
            end
            mman = s ? 28'(-q) : 28'(q);
            mexp = 15'(p + n + 2);
            if (e == 0) mlat = 3 + 52 - n;
        end
    endtask

    task automatic run_conv(input logic [63:0] v, output int lat);
        @(posedge clk); #1;
        fp_i = v;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_conv(input logic [63:0] v, input string tag);
        logic [14:0] mexp;
        logic [27:0] mman;
        logic        minx, mnan;
        int          mlat;
        model(v, mexp, mman, minx, mnan, mlat);
        run_conv(v, d_lat);
        check({tag, "/latency"}, 64'(d_lat), 64'(mlat));
        check({tag, "/exp"}, 64'(exp_o), 64'(mexp));
        check({tag, "/man"}, 64'(man_o), 64'(mman));
        check({tag, "/inexact"}, 64'(inexact_o), 64'(minx));
        check({tag, "/nan"}, 64'(nan_o), 64'(mnan));
        check({tag, "/busy_at_done"}, 64'(busy_o), 64'd1);
        d_exp = exp_o;
        d_man = man_o;
        d_inx = inexact_o;
        d_nan = nan_o;
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 64'(done_o), 64'd0);
        check({tag, "/man_hold"}, 64'(man_o), 64'(mman));
    endtask

    initial begin
        logic [63:0] v;
        int          lat;
        int          sel;
        logic        seen;

        rst_ni  = 1'b0;
        cke_i   = 1'b1;
        start_i = 1'b0;
        fp_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 64'(busy_o), 64'd0);
        check("reset/done", 64'(done_o), 64'd0);
        check("reset/exp", 64'(exp_o), 64'd0);
        check("reset/man", 64'(man_o), 64'd0);
        check("reset/inexact", 64'(inexact_o), 64'd0);
        check("reset/nan", 64'(nan_o), 64'd0);
        rst_ni = 1'b1;

        check_conv(64'h3FF0000000000000, "one");
        check("one/man_k", 64'(d_man), 64'h4000000);
        check("one/exp_k", 64'(d_exp), 64'd2);
        check("one/lat_k", 64'(d_lat), 64'd3);
        check_conv(64'hC004000000000000, "m2p5");
        check("m2p5/man_k", 64'(d_man), 64'hB000000);
        check("m2p5/exp_k", 64'(d_exp), 64'd3);
        check_conv(64'hBFF0000000000000, "m1");
        check("m1/man_k", 64'(d_man), 64'hC000000);
        check_conv(64'h3FF0000006000000, "tie_odd");
        check("tie_odd/man_k", 64'(d_man), 64'h4000002);
        check("tie_odd/inx_k", 64'(d_inx), 64'd1);
        check_conv(64'h3FF0000002000000, "tie_even");
        check("tie_even/man_k", 64'(d_man), 64'h4000000);
        check("tie_even/inx_k", 64'(d_inx), 64'd1);
        check_conv(64'h3FFFFFFFFFFFFFFF, "carry");
        check("carry/man_k", 64'(d_man), 64'h4000000);
        check("carry/exp_k", 64'(d_exp), 64'd3);
        check_conv(64'h0000000000000001, "min_sub");
        check("min_sub/man_k", 64'(d_man), 64'h4000000);
        check("min_sub/exp_k", 64'(d_exp), 64'h7BD0);
        check("min_sub/lat_k", 64'(d_lat), 64'd55);
        check_conv(64'h8000000000000000, "mzero");
        check("mzero/exp_k", 64'(d_exp), 64'h4000);
        check("mzero/man_k", 64'(d_man), 64'd0);
        check_conv(64'hFFF0000000000000, "minf");
        check("minf/man_k", 64'(d_man), 64'h8000001);
        check("minf/exp_k", 64'(d_exp), 64'h3FFF);
        check_conv(64'h7FF8000000000000, "nan");
        check("nan/nan_k", 64'(d_nan), 64'd1);
        check("nan/man_k", 64'(d_man), 64'h7FFFFFF);

        // Start held high while busy: only the first operand is converted.
        @(posedge clk); #1;
        fp_i = 64'h0000000000000001;
        start_i = 1'b1;
        @(posedge clk); #1;
        fp_i = 64'h3FF0000000000000;
        lat = 1;
        while (done_o !== 1'b1 && lat < 300) begin
            if (lat == 10) start_i = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_start/lat", 64'(lat), 64'd55);
        check("busy_start/man", 64'(man_o), 64'h4000000);
        check("busy_start/exp", 64'(exp_o), 64'h7BD0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check("busy_start/no_requeue", 64'(seen), 64'd0);

        // Clock-enable stall of 5 cycles in the middle of normalization.
        @(posedge clk); #1;
        fp_i = 64'h0000000000000001;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 1;
        while (done_o !== 1'b1 && lat < 300) begin
            if (lat == 10) cke_i = 1'b0;
            if (lat == 12) check("stall/busy", 64'(busy_o), 64'd1);
            if (lat == 15) cke_i = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("stall/lat", 64'(lat), 64'd60);
        check("stall/exp", 64'(exp_o), 64'h7BD0);
        @(posedge clk); #1;
        check("stall/done_pulse", 64'(done_o), 64'd0);

        // Reset asserted while in ROUND aborts the conversion.
        check_conv(64'hC004000000000000, "pre_rst");
        @(posedge clk); #1;
        fp_i = 64'h3FF0000000000000;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        check("abort/done", 64'(done_o), 64'd0);
        check("abort/busy", 64'(busy_o), 64'd0);
        check("abort/man", 64'(man_o), 64'd0);
        check("abort/exp", 64'(exp_o), 64'd0);
        check("abort/inexact", 64'(inexact_o), 64'd0);
        rst_ni = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check("abort/no_done", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            v = {$urandom, $urandom};
            sel = int'($urandom_range(0, 9));
            if (sel <= 5) begin
                v[62:52] = 11'($urandom_range(1, 2046));
                if (sel == 5) v[24:0] = 25'h1000000;
            end else if (sel <= 7) begin
                v[62:52] = '0;
                v[51:0] = v[51:0] >> $urandom_range(0, 51);
                if (v[51:0] == '0) v[0] = 1'b1;
            end else if (sel == 8) begin
                v[62:52] = '1;
                if ($urandom_range(0, 1) == 0) v[51:0] = '0;
            end else begin
                v[62:0] = '0;
            end
            check_conv(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
